// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Turns a MEM-stage load/store request of byte, half or word size into a
// sequence of single-byte transfers on a narrow memory port. Multi-byte
// accesses are big-endian: byte index 0 is at the lowest address and is the
// most significant byte of the value. Misaligned or illegal-size requests
// complete immediately with an error and never touch the memory port.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   req_valid/req_ready  request handshake (accepted only in IDLE)
//   req_load, req_size,
//   req_signed, req_addr,
//   req_wdata            request attributes, latched on accept
//   resp_valid           one-cycle completion pulse
//   resp_rdata, resp_err completion data / error flag (valid with resp_valid)
//   busy                 stall request to the pipeline
//   mem_req, mem_we,
//   mem_addr, mem_wdata  byte-port request, held stable until mem_ack
//   mem_rdata, mem_ack   byte-port read data and transfer completion
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_load,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack
);

   localparam logic [1:0] SizeWord = 2'b01;
   localparam logic [1:0] SizeByte = 2'b10;
   localparam logic [1:0] SizeHalf = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic                r_load;
   logic                r_signed;
   logic                r_err;
   logic [1:0]          r_size;
   logic [1:0]          r_idx;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_asm;

   logic                w_accept;
   logic                w_req_err;
   logic [1:0]          w_last_idx;
   logic [1:0]          w_sel;
   logic [7:0]          w_store_byte;
   logic [31:0]         w_ext;

   assign w_accept = req_valid && (r_state == StIdle);

   // Alignment / size legality of the incoming request.
   always_comb begin
      w_req_err = 1'b0;
      unique case (req_size)
         SizeWord: w_req_err = (req_addr[1:0] != 2'b00);
         SizeHalf: w_req_err = req_addr[0];
         SizeByte: w_req_err = 1'b0;
         default:  w_req_err = 1'b1;
      endcase
   end

   // Index of the final byte of the latched access (byte count - 1).
   always_comb begin
      w_last_idx = 2'd0;
      unique case (r_size)
         SizeWord: w_last_idx = 2'd3;
         SizeHalf: w_last_idx = 2'd1;
         default:  w_last_idx = 2'd0;
      endcase
   end

   // Big-endian: index 0 sends the most significant store byte.
   assign w_sel        = w_last_idx - r_idx;
   assign w_store_byte = r_wdata[{w_sel, 3'b000} +: 8];

   // Bytes were shifted in from the LSB end, so the value is right-justified.
   always_comb begin
      w_ext = r_asm;
      unique case (r_size)
         SizeByte: w_ext = {{24{r_signed & r_asm[7]}}, r_asm[7:0]};
         SizeHalf: w_ext = {{16{r_signed & r_asm[15]}}, r_asm[15:0]};
         default:  w_ext = r_asm;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_load   <= 1'b0;
         r_signed <= 1'b0;
         r_err    <= 1'b0;
         r_size   <= 2'b00;
         r_idx    <= 2'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_asm    <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_load   <= req_load;
            r_signed <= req_signed;
            r_err    <= w_req_err;
            r_size   <= req_size;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_idx    <= 2'd0;
            r_asm    <= 32'd0;
         end else if ((r_state == StAccess) && mem_ack) begin
            if (r_idx != w_last_idx) begin
               r_idx <= r_idx + 2'd1;
            end
            if (r_load) begin
               r_asm <= {r_asm[23:0], mem_rdata};
            end
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      busy         = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = 8'd0;
      resp_valid   = 1'b0;
      resp_err     = 1'b0;
      resp_rdata   = 32'd0;
      unique case (r_state)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_next = w_req_err ? StResp : StAccess;
            end
         end
         StAccess: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = !r_load;
            mem_addr  = r_addr + ADDR_W'(r_idx);
            mem_wdata = r_load ? 8'd0 : w_store_byte;
            if (mem_ack && (r_idx == w_last_idx)) begin
               w_state_next = StResp;
            end
         end
         StResp: begin
            busy         = 1'b1;
            resp_valid   = 1'b1;
            resp_err     = r_err;
            resp_rdata   = (r_load && !r_err) ? w_ext : 32'd0;
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit: a 256-byte memory model answers the byte
// port with a programmable number of wait cycles per byte; one linear initial
// block issues requests and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_load;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   int          checks;
   int          errors;
   int          ack_delay;
   int          wait_cnt;
   int          lat;
   logic [7:0]  mem [256];
   logic [7:0]  exp_b [4];

   mem_access_unit #(
      .ADDR_W(32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_load   (req_load),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder: acknowledge after ack_delay wait cycles of a held mem_req.
   always @(negedge clk) begin
      mem_rdata <= mem[mem_addr[7:0]];
      if (mem_req) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack  <= 1'b1;
            wait_cnt <= 0;
         end else begin
            mem_ack  <= 1'b0;
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         mem_ack  <= 1'b0;
         wait_cnt <= 0;
      end
   end

   always @(posedge clk) begin
      if (mem_req && mem_we && mem_ack) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and pass the accept edge.
   task automatic issue(input logic ld, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd);
      check("ready_before_issue", {31'd0, req_ready}, 32'd1);
      req_load   = ld;
      req_size   = sz;
      req_signed = sg;
      req_addr   = ad;
      req_wdata  = wd;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   // Latency counted in edges from the accept edge; bounded.
   task automatic wait_resp(output int n);
      n = 1;
      while (!resp_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      ack_delay  = 0;
      wait_cnt   = 0;
      mem_ack    = 1'b0;
      mem_rdata  = 8'd0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_load   = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
      #1;
      mem[8'h10] <= 8'h11;
      mem[8'h11] <= 8'h22;
      mem[8'h12] <= 8'h33;
      mem[8'h13] <= 8'h44;
      mem[8'h06] <= 8'h80;
      mem[8'h07] <= 8'h01;
      mem[8'h20] <= 8'h9C;

      // Reset state
      tick();
      tick();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // Word load, ack every cycle
      issue(1'b1, 2'b01, 1'b0, 32'h10, 32'd0);
      check("wl_busy", {31'd0, busy}, 32'd1);
      check("wl_ready", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("wl_mem_req", {31'd0, mem_req}, 32'd1);
         check("wl_mem_we", {31'd0, mem_we}, 32'd0);
         check("wl_mem_addr", mem_addr, 32'h10 + i);
         check("wl_no_resp", {31'd0, resp_valid}, 32'd0);
         tick();
      end
      check("wl_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("wl_rdata", resp_rdata, 32'h11223344);
      check("wl_err", {31'd0, resp_err}, 32'd0);
      check("wl_mem_req_off", {31'd0, mem_req}, 32'd0);
      tick();
      check("wl_back_idle", {31'd0, req_ready}, 32'd1);
      check("wl_pulse_one", {31'd0, resp_valid}, 32'd0);

      // Signed / unsigned half load
      issue(1'b1, 2'b11, 1'b1, 32'h06, 32'd0);
      wait_resp(lat);
      check("hs_latency", lat, 32'd3);
      check("hs_rdata", resp_rdata, 32'hFFFF8001);
      tick();
      issue(1'b1, 2'b11, 1'b0, 32'h06, 32'd0);
      wait_resp(lat);
      check("hu_latency", lat, 32'd3);
      check("hu_rdata", resp_rdata, 32'h00008001);
      tick();

      // Signed / unsigned byte load
      issue(1'b1, 2'b10, 1'b1, 32'h20, 32'd0);
      wait_resp(lat);
      check("bs_latency", lat, 32'd2);
      check("bs_rdata", resp_rdata, 32'hFFFFFF9C);
      tick();
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'd0);
      wait_resp(lat);
      check("bu_rdata", resp_rdata, 32'h0000009C);
      tick();

      // Byte store
      issue(1'b0, 2'b10, 1'b0, 32'h03, 32'h000000A5);
      check("bst_mem_we", {31'd0, mem_we}, 32'd1);
      check("bst_mem_addr", mem_addr, 32'h03);
      check("bst_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
      tick();
      check("bst_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("bst_rdata", resp_rdata, 32'd0);
      check("bst_err", {31'd0, resp_err}, 32'd0);
      check("bst_mem_req_off", {31'd0, mem_req}, 32'd0);
      check("bst_mem_content", {24'd0, mem[8'h03]}, 32'hA5);
      tick();

      // Error cases: misaligned word, misaligned half, illegal size
      issue(1'b1, 2'b01, 1'b0, 32'h02, 32'd0);
      check("mw_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("mw_err", {31'd0, resp_err}, 32'd1);
      check("mw_rdata", resp_rdata, 32'd0);
      check("mw_no_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
      check("mw_idle", {31'd0, req_ready}, 32'd1);
      check("mw_no_mem_req2", {31'd0, mem_req}, 32'd0);
      issue(1'b1, 2'b11, 1'b1, 32'h07, 32'd0);
      check("mh_err", {31'd0, resp_err}, 32'd1);
      check("mh_no_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
      issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h12345678);
      check("sz0_err", {31'd0, resp_err}, 32'd1);
      check("sz0_valid", {31'd0, resp_valid}, 32'd1);
      check("sz0_no_mem_req", {31'd0, mem_req}, 32'd0);
      tick();

      // Word store with three wait cycles per byte; stray req_valid pulses
      ack_delay = 3;
      exp_b[0] = 8'hDE;
      exp_b[1] = 8'hAD;
      exp_b[2] = 8'hBE;
      exp_b[3] = 8'hEF;
      issue(1'b0, 2'b01, 1'b0, 32'h40, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < 4; c++) begin
            check("ws_mem_req", {31'd0, mem_req}, 32'd1);
            check("ws_mem_addr", mem_addr, 32'h40 + i);
            check("ws_mem_wdata", {24'd0, mem_wdata}, {24'd0, exp_b[i]});
            if (c == 1) begin
               req_load  = 1'b1;
               req_size  = 2'b10;
               req_addr  = 32'h10;
               req_valid = 1'b1;
            end
            tick();
            req_valid = 1'b0;
         end
      end
      check("ws_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("ws_rdata", resp_rdata, 32'd0);
      check("ws_mem_bytes", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hDEADBEEF);
      tick();
      check("ws_idle", {31'd0, req_ready}, 32'd1);
      tick();
      check("ws_ignored_req", {30'd0, busy, mem_req}, 32'd0);
      ack_delay = 0;

      // Reset in the middle of a word store after two acks
      issue(1'b0, 2'b01, 1'b0, 32'h50, 32'h12345678);
      tick();
      tick();
      check("rs_mid_addr", mem_addr, 32'h52);
      rst_n = 1'b0;
      tick();
      check("rs_mem_req", {31'd0, mem_req}, 32'd0);
      check("rs_ready", {31'd0, req_ready}, 32'd1);
      check("rs_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rs_partial", {16'd0, mem[8'h50], mem[8'h51]}, 32'h00001234);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rs_no_resp", {30'd0, resp_valid, mem_req}, 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
